// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-and-add multiplier controller.
// Multiplies two unsigned W-bit operands into a 2W-bit product by driving one
// 2W-bit adder iteratively, one partial product per clock.
//
// Optional feature macro: EARLY_EXIT_EN
//   defined   -> the ADD phase also ends as soon as the remaining multiplier
//                bits are all zero (latency depends on b, result identical).
//   undefined -> always exactly W iterations (constant latency).
//
// Handshake: start is sampled only while busy=0 (state IDLE or DONE); an
// accepted start captures a/b on that edge. busy=1 for every ADD cycle, done
// is a one-cycle pulse in the DONE state, and product updates only on the
// ADD->DONE edge and holds until the next completion.

module mult_seq_ctrl #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           busy_nxt;
   logic           done_nxt;

   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] addend;
   logic [2*W-1:0] sum;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic           accept;
   logic           last_iter;

   // start is only honoured when no operation is in flight
   assign accept = (state != S_ADD) && start;

   // Partial-product select feeding the shared adder (carry-in 0, carry-out dropped)
   always_comb begin
      addend = mplier[0] ? mcand : '0;
   end

   assign sum = acc + addend;

`ifdef EARLY_EXIT_EN
   // Stop after the last set multiplier bit, or after W iterations at most
   assign last_iter = (cnt == CW'(W - 1)) || ((mplier >> 1) == '0);
`else
   // Constant latency: always W iterations
   assign last_iter = (cnt == CW'(W - 1));
`endif

   // State register plus registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ADD;
         S_ADD:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_ADD : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so busy/done come straight from flops
   always_comb begin
      busy_nxt = (state_nxt == S_ADD);
      done_nxt = (state_nxt == S_DONE);
   end

   // Datapath: operand capture, shift-and-add iteration, result latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (state == S_ADD) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (last_iter) product <= sum;
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: self-checking bench for mult_seq_ctrl.
// Reference model: product = a*b, latency = W iterations (or the index of the
// highest set bit of b plus one, minimum 1, when EARLY_EXIT_EN is defined).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_mult_seq_ctrl;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_tests = 0;
   int n_fail  = 0;
   int accepts = 0;
   int done_cnt = 0;
   logic [2*W-1:0] last_p = '0;
   logic [2*W-1:0] exp_q[$];

   mult_seq_ctrl #(.W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int iters(input logic [W-1:0] bv);
`ifdef EARLY_EXIT_EN
      int n;
      n = 1;
      for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
      return n;
`else
      return W + 0 * int'(bv[0]);
`endif
   endfunction

   function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
   endfunction

   // ---------------- driver: one operation with full checking ----------------
   task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input bit noise, input string name);
      int exp_lat;
      int lat;
      int busy_n;
      bit seen;
      logic [2*W-1:0] exp_p;
      exp_lat = iters(tbv);
      @(negedge clk);
      start = 1'b1; a = ta; b = tbv;
      exp_q.push_back(mul_ref(ta, tbv));
      @(negedge clk);                        // after accept edge
      accepts++;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      busy_n = busy ? 1 : 0;
      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= W + 4 && !seen; k++) begin
         if (noise && k <= exp_lat) begin
            start = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            lat = k;
         end else begin
            if (busy) busy_n++;
            n_tests++;
            if (product !== last_p) begin
               n_fail++;
               $display("FAIL %s held: product=%0d required=%0d", name, product, last_p);
            end
         end
      end
      start = 1'b0;
      exp_p = exp_q.pop_front();
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s timeout: no done within %0d cycles", name, W + 4);
      end else begin
         done_cnt++;
         n_tests++;
         if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got=%0d required=%0d", name, lat, exp_lat);
         end
         if (product !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: got=%0d required=%0d (a=%0d b=%0d)", name, product, exp_p, ta, tbv);
         end
      end
      n_tests++;
      if (busy_n !== exp_lat) begin
         n_fail++;
         $display("FAIL %s busy_cycles: got=%0d required=%0d", name, busy_n, exp_lat);
      end
      last_p = exp_p;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== last_p) begin
         n_fail++;
         $display("FAIL %s after_done: done=%0b busy=%0b product=%0d required 0 0 %0d",
                  name, done, busy, product, last_p);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         n_fail++;
         $display("FAIL reset_async: busy=%0b done=%0b product=%0d required 0 0 0", busy, done, product);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%0b done=%0b product=%0d required 0 0 0", busy, done, product);
      end
      last_p = '0;
   endtask

   task automatic test_full_scale;
      run_one(8'd255, 8'd255, 1'b0, "full_scale");
      n_tests++;
      if (product !== 16'hFE01) begin
         n_fail++;
         $display("FAIL full_scale_const: product=%0h required=fe01", product);
      end
   endtask

   task automatic test_zero;
      run_one(8'd0, 8'd0, 1'b0, "zero_zero");
      run_one(8'd200, 8'd0, 1'b0, "a200_zero");
      run_one(8'd0, 8'd77, 1'b0, "zero_b77");
   endtask

   task automatic test_early_exit;
      run_one(8'd13, 8'd11, 1'b0, "early_13x11");
      run_one(8'd250, 8'd1, 1'b0, "early_b1");
      run_one(8'd99, 8'd128, 1'b0, "early_b128");
   endtask

   task automatic test_handshake;
      int l1;
      int l2;
      int lat;
      bit seen;
      l1 = iters(8'd7);
      l2 = iters(8'd100);
      @(negedge clk);
      start = 1'b1; a = 8'd3; b = 8'd7;
      @(negedge clk);                        // after accept edge
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      for (int c = 0; c < l1; c++) begin
         if (c == l1 - 1) begin
            start = 1'b1; a = 8'd100; b = 8'd100;
         end else if (c == 2 || c == 5) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (c + 1 < l1) begin
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL hs_busy c=%0d: done=%0b busy=%0b required 0 1", c + 1, done, busy);
            end
         end
      end
      n_tests++;
      if (done !== 1'b1 || product !== 16'd21) begin
         n_fail++;
         $display("FAIL hs_first: done=%0b product=%0d required 1 21", done, product);
      end
      last_p = 16'd21;
      @(negedge clk);                        // second op accepted on the done-cycle edge
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== 16'd21) begin
         n_fail++;
         $display("FAIL hs_reaccept: busy=%0b done=%0b product=%0d required 1 0 21", busy, done, product);
      end
      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= W + 4 && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            lat = k;
         end else begin
            n_tests++;
            if (product !== 16'd21) begin
               n_fail++;
               $display("FAIL hs_hold: product=%0d required 21", product);
            end
         end
      end
      n_tests++;
      if (!seen || lat !== l2 || product !== 16'd10000) begin
         n_fail++;
         $display("FAIL hs_second: seen=%0b lat=%0d product=%0d required 1 %0d 10000", seen, lat, product, l2);
      end
      last_p = 16'd10000;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      bit saw_done;
      run_one(8'd3, 8'd7, 1'b0, "pre_reset");
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_op: busy=%0b done=%0b product=%0d required 0 0 0", busy, done, product);
      end
      last_p = '0;
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done !== 1'b0 || product !== '0) begin
         n_fail++;
         $display("FAIL reset_no_done: activity=%0b product=%0d required 0 0", saw_done, product);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2*W-1:0] ep;
      int cyc;
      int ndone;
      int lat_exp;
      exp_q.delete();
      ra = W'($urandom); rb = W'($urandom);
      @(negedge clk);
      start = 1'b1; a = ra; b = rb;
      exp_q.push_back(mul_ref(ra, rb));
      lat_exp = iters(rb);
      cyc = 0;
      ndone = 0;
      for (int g = 0; g < 2000 && ndone < 20; g++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ndone++;
            n_tests++;
            if (cyc !== lat_exp + 1) begin
               n_fail++;
               $display("FAIL b2b_period #%0d: got=%0d required=%0d", ndone, cyc, lat_exp + 1);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra_done #%0d: product=%0d required none", ndone, product);
            end else begin
               ep = exp_q.pop_front();
               if (product !== ep) begin
                  n_fail++;
                  $display("FAIL b2b_product #%0d: got=%0d required=%0d", ndone, product, ep);
               end
               last_p = ep;
            end
            if (ndone < 20) begin
               ra = W'($urandom); rb = W'($urandom);
               a = ra; b = rb;
               exp_q.push_back(mul_ref(ra, rb));
               lat_exp = iters(rb);
            end else begin
               start = 1'b0;
            end
            cyc = 0;
         end else begin
            a = W'($urandom); b = W'($urandom);
         end
      end
      start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ndone !== 20 || exp_q.size() !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_count: dones=%0d pending=%0d busy=%0b required 20 0 0", ndone, exp_q.size(), busy);
      end
      exp_q.delete();
   endtask

   task automatic test_random_sweep;
      accepts = 0;
      done_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         run_one(W'($urandom), W'($urandom), 1'b1, "sweep");
      end
      n_tests++;
      if (done_cnt !== accepts) begin
         n_fail++;
         $display("FAIL sweep_done_count: dones=%0d required=%0d", done_cnt, accepts);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_full_scale();
      test_zero();
      test_early_exit();
      test_handshake();
      test_reset_mid_op();
      test_back_to_back();
      test_random_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-and-add multiplier controller: multiplies two unsigned W-bit operands into a 2W-bit product by driving a single 2W-bit ripple-carry adder iteratively, one partial product per clock, instead of a full array. Sits between the tile's operand/handshake registers and the shared adder datapath. It owns the multiplicand/multiplier shift registers, the accumulator, the iteration counter and the start/busy/done handshake.

## Interface

- W, 8, operand width; adder and accumulator are 2W bits (16 at default).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  W  multiplicand, captured when start is accepted.
- b  in  W  multiplier, captured when start is accepted.
- busy  out  1  operation in progress; reset 0.
- done  out  1  single-cycle completion pulse; reset 0.
- product  out  2W  last completed result, held until next completion; reset 0.

## Operation

- States: IDLE, ADD, DONE. Reset → IDLE.
- IDLE/DONE with start=1 (accept):
  - mcand ← {W'b0, a}
  - mplier ← b
  - acc ← 0
  - cnt ← 0
  - → ADD
- IDLE with start=0: stay.
- DONE with start=0: → IDLE.
- ADD, each cycle:
  - acc ← acc + (mplier[0] ? mcand : 0), computed through the 2W-bit adder with carry-in 0; adder carry-out ignored, since the product always fits in 2W bits.
  - mcand ← mcand << 1
  - mplier ← mplier >> 1
  - cnt ← cnt + 1
- ADD exit: when cnt = W-1 (last iteration), or earlier per Configuration. On exit: product ← updated acc value, → DONE.
- DONE: done=1 for exactly that one cycle; busy=0.
- busy=1 in ADD only.
- start while busy=1 is ignored: no queuing, operands not recaptured.
- a/b may change freely after acceptance.
- product changes only on the ADD→DONE edge; it never shows intermediate accumulator values.
- rst_n low at any time, including mid-ADD, asynchronously clears state, acc, mcand, mplier, cnt, busy, done and product. The in-flight operation is discarded. No done pulse follows reset release.
- cnt width: clog2(W) bits, minimum 1.

## Timing

- Accept edge = rising edge at which state ∈ {IDLE, DONE} and start=1. Call it edge 0.
- Fixed-latency mode:
  - ADD iterations complete at edges 1..W.
  - busy=1 after edge 0 through edge W.
  - done=1 and the new product are visible after edge W, for one cycle.
  - Throughput: one result per W+1 cycles with back-to-back starts. A start asserted during the DONE cycle is accepted at edge W+1.
- All outputs are registered; there is no combinational path from start/a/b to any output.
- Adder critical path: one 2W-bit ripple plus an acc mux per cycle.

## Configuration

- EARLY_EXIT_EN defined:
  - ADD also exits when the post-shift multiplier (mplier >> 1) equals 0.
  - Iterations = max(1, position of highest set bit of b + 1).
  - b=0 → 1 iteration, so done is visible after edge 1.
  - Result is identical to fixed mode.
- EARLY_EXIT_EN undefined:
  - Always exactly W iterations, independent of b.
  - Constant-latency behaviour, for timing-side-channel-free and deterministic scheduling.

## Test plan

- Reset mid-op: accept a=8'hFF, b=8'hFF; drop rst_n after 3 ADD cycles → busy=0, done=0, product=0 immediately. Release rst_n; no done pulse within 20 cycles.
- Full-scale, fixed mode: a=255, b=255 → done exactly 8 cycles after accept edge, product=16'hFE01; busy high 8 cycles; done high 1 cycle.
- Zero operands: a=0, b=0 and a=200, b=0 → product=0. Done after 8 cycles without EARLY_EXIT_EN, after 1 cycle with it.
- Early exit: with EARLY_EXIT_EN, a=13, b=11 (4'b1011) → product=143, done 4 cycles after accept. Without EARLY_EXIT_EN → 143 after 8 cycles.
- Handshake:
  - start pulsed at cycles 2 and 5 of a busy op (a=3, b=7) → ignored, product=21.
  - Hold start=1 with new a=100, b=100 through the done cycle → second op accepted on the done-cycle edge; product=10000 after another 8 cycles, and 21 held until then.
- Random sweep: 1000 random a/b pairs in both configurations → product == a*b, done count == accepted-start count.
